// File: rtl/ntt_pkg.sv
// ntt_pkg: shared width, Kyber modulus, butterfly FSM states and modular add/sub helpers.
//   NTT_WIDTH  default coefficient width
//   KYBER_Q    Kyber modulus 3329
//   state_t    IDLE -> MUL -> ADDSUB -> DONE
//   mod_add    (x + y) mod q for x, y < q
//   mod_sub    (x - y) mod q for x, y < q
package ntt_pkg;
    localparam int NTT_WIDTH = 12;
    localparam logic [NTT_WIDTH-1:0] KYBER_Q = 12'd3329;
    typedef enum logic [1:0] {IDLE, MUL, ADDSUB, DONE} state_t;
    // The extra top bit holds x + y (< 2q) without overflow before the conditional subtract.
    function automatic logic [NTT_WIDTH:0] mod_add(input logic [NTT_WIDTH:0] x, input logic [NTT_WIDTH:0] y,
                                                   input logic [NTT_WIDTH:0] q);
        logic [NTT_WIDTH:0] s;
        s = x + y;
        return (s >= q) ? s - q : s;
    endfunction
    function automatic logic [NTT_WIDTH:0] mod_sub(input logic [NTT_WIDTH:0] x, input logic [NTT_WIDTH:0] y,
                                                   input logic [NTT_WIDTH:0] q);
        return (x >= y) ? x - y : x + q - y;
    endfunction
endpackage

// File: rtl/ntt_butterfly_12b_if.sv
// ntt_butterfly_12b_if: operand/result handshake bus of the NTT butterfly.
//   q_i, a_i, b_i, w_i  modulus and operands (master -> slave)
//   valid_i / ready_o   input handshake
//   x_o, y_o            butterfly results (slave -> master)
//   valid_o / ready_i   output handshake
interface ntt_butterfly_12b_if import ntt_pkg::*; #(parameter int WIDTH = NTT_WIDTH) ();
    logic [WIDTH-1:0] q_i, a_i, b_i, w_i, x_o, y_o;
    logic             valid_i, ready_o, valid_o, ready_i;
    modport master (output q_i, a_i, b_i, w_i, valid_i, ready_i, input ready_o, x_o, y_o, valid_o);
    modport slave  (input q_i, a_i, b_i, w_i, valid_i, ready_i, output ready_o, x_o, y_o, valid_o);
endinterface

// File: rtl/modmul_serial.sv
// modmul_serial: bit-serial interleaved modular multiply t = w*b mod q, one w bit per cycle, MSB first.
//   clock_i, nreset_i  clock, async active-low reset
//   start_i            clears t and loads the bit counter
//   q_i, b_i, w_i      registered operands held stable by the parent
//   t_o                running/final product
//   done_o             high during the last (cnt==0) iteration cycle
module modmul_serial import ntt_pkg::*; #(parameter int WIDTH = NTT_WIDTH) (
    input  logic             clock_i,
    input  logic             nreset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] w_i,
    output logic [WIDTH:0]   t_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH:0]  t_q, t_d, dbl, acc;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    always_comb begin
        dbl    = mod_add(t_q, t_q, (WIDTH+1)'(q_i));
        acc    = w_i[cnt_q] ? mod_add(dbl, (WIDTH+1)'(b_i), (WIDTH+1)'(q_i)) : dbl;
        t_d    = start_i ? '0 : busy_q ? acc : t_q;
        cnt_d  = start_i ? CW'(WIDTH-1) : busy_q ? cnt_q - 1'b1 : cnt_q;
        busy_d = start_i | (busy_q & (cnt_q != '0));
    end
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            t_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end
    assign t_o    = t_q;
    assign done_o = busy_q && (cnt_q == '0);
endmodule

// File: rtl/ntt_butterfly_12b.sv
// ntt_butterfly_12b: Cooley-Tukey butterfly x = (a + w*b) mod q, y = (a - w*b) mod q.
//   clock_i   rising-edge clock
//   nreset_i  async active-low reset
//   bus       slave side of ntt_butterfly_12b_if (operands, results, valid/ready both ways)
// Accept in IDLE, WIDTH serial multiply cycles, one add/sub cycle, then hold in DONE until ready_i.
module ntt_butterfly_12b import ntt_pkg::*; #(parameter int WIDTH = NTT_WIDTH) (
    input  logic                 clock_i,
    input  logic                 nreset_i,
    ntt_butterfly_12b_if.slave   bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, a_q, a_d, b_q, b_d, w_q, w_d, x_q, x_d, y_q, y_d;
    logic             valid_q, valid_d, start, mul_done;
    logic [WIDTH:0]   t, sum_x, dif_y;
    modmul_serial #(.WIDTH(WIDTH)) u_mul (
        .clock_i (clock_i),
        .nreset_i(nreset_i),
        .start_i (start),
        .q_i     (q_q),
        .b_i     (b_q),
        .w_i     (w_q),
        .t_o     (t),
        .done_o  (mul_done)
    );
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        a_d     = a_q;
        b_d     = b_q;
        w_d     = w_q;
        x_d     = x_q;
        y_d     = y_q;
        valid_d = valid_q;
        start   = 1'b0;
        sum_x   = mod_add((WIDTH+1)'(a_q), t, (WIDTH+1)'(q_q));
        dif_y   = mod_sub((WIDTH+1)'(a_q), t, (WIDTH+1)'(q_q));
        case (state_q)
            IDLE: if (bus.valid_i) begin
                q_d     = bus.q_i;
                a_d     = bus.a_i;
                b_d     = bus.b_i;
                w_d     = bus.w_i;
                start   = 1'b1;
                state_d = MUL;
            end
            MUL: state_d = mul_done ? ADDSUB : MUL;
            ADDSUB: begin
                x_d     = WIDTH'(sum_x);
                y_d     = WIDTH'(dif_y);
                valid_d = 1'b1;
                state_d = DONE;
            end
            DONE: if (bus.ready_i) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= IDLE;
            q_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w_q     <= w_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end
    assign bus.ready_o = (state_q == IDLE);
    assign bus.x_o     = x_q;
    assign bus.y_o     = y_q;
    assign bus.valid_o = valid_q;
endmodule
